// File: rtl/palette_cmd_sequencer.sv
// Palette/display command sequencer: turns one request into 1..3 registered command words.
// Optional build macro PALSEQ_SKIP_SEL_EN skips the palette-select command when the palette is already selected.
module palette_cmd_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [2:0]  req_pal,
  input  logic [19:0] req_colors,
  input  logic [6:0]  req_delta,
  input  logic        cmd_hold,
  output logic [23:0] cmd_out,
  output logic        cmd_start,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, SEL, C12, C34, ONE} state_t;

  state_t      state_q, state_d;
  logic [23:0] cmd_out_q, cmd_out_d;
  logic        cmd_start_q, cmd_start_d;
  logic        done_q, done_d;
  logic [1:0]  kind_q, kind_d;
  logic [2:0]  pal_q, pal_d;
  logic [19:0] colors_q, colors_d;
  logic [6:0]  delta_q, delta_d;
  logic        accept;
  logic        skip_hit;

  function automatic logic [23:0] sel_word(input logic [2:0] pal);
    return {8'd3, 13'd0, pal};
  endfunction

  function automatic logic [23:0] c12_word(input logic [19:0] colors);
    return {8'd4, 6'd0, colors[9:0]};
  endfunction

  function automatic logic [23:0] c34_word(input logic [19:0] colors);
    return {8'd5, 6'd0, colors[19:10]};
  endfunction

  function automatic logic [23:0] one_word(input logic [1:0] kind, input logic [6:0] delta);
    case (kind)
      2'd1:    return {8'd1, 9'd0, delta};
      2'd2:    return {8'd2, 11'd0, delta[4:0]};
      default: return {8'd36, 16'h0000};
    endcase
  endfunction

  // Ready stays low through the done cycle so back-to-back requests get an idle gap.
  assign req_ready = (state_q == IDLE) && !done_q;
  assign accept    = req_valid && req_ready;

`ifdef PALSEQ_SKIP_SEL_EN
  logic [2:0] shadow_pal_q;
  logic       shadow_vld_q;
  logic       shadow_wr;
  logic [2:0] shadow_wr_pal;

  assign skip_hit = shadow_vld_q && (req_pal == shadow_pal_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_pal_q <= 3'd0;
      shadow_vld_q <= 1'b0;
    end else if (shadow_wr) begin
      shadow_pal_q <= shadow_wr_pal;
      shadow_vld_q <= 1'b1;
    end
  end
`else
  assign skip_hit = 1'b0;
`endif

  // The first command is built straight from the request inputs so it lands one cycle after accept.
  always_comb begin
    state_d     = state_q;
    cmd_out_d   = cmd_out_q;
    cmd_start_d = 1'b0;
    done_d      = 1'b0;
    kind_d      = kind_q;
    pal_d       = pal_q;
    colors_d    = colors_q;
    delta_d     = delta_q;
`ifdef PALSEQ_SKIP_SEL_EN
    shadow_wr     = 1'b0;
    shadow_wr_pal = pal_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          kind_d   = req_kind;
          pal_d    = req_pal;
          colors_d = req_colors;
          delta_d  = req_delta;
          if (req_kind == 2'd0) begin
            if (skip_hit) begin
              state_d = C12;
              if (!cmd_hold) begin
                cmd_out_d   = c12_word(req_colors);
                cmd_start_d = 1'b1;
                state_d     = C34;
              end
            end else begin
              state_d = SEL;
              if (!cmd_hold) begin
                cmd_out_d   = sel_word(req_pal);
                cmd_start_d = 1'b1;
                state_d     = C12;
`ifdef PALSEQ_SKIP_SEL_EN
                shadow_wr     = 1'b1;
                shadow_wr_pal = req_pal;
`endif
              end
            end
          end else begin
            state_d = ONE;
            if (!cmd_hold) begin
              cmd_out_d   = one_word(req_kind, req_delta);
              cmd_start_d = 1'b1;
              done_d      = 1'b1;
              state_d     = IDLE;
            end
          end
        end
      end
      SEL: if (!cmd_hold) begin
        cmd_out_d   = sel_word(pal_q);
        cmd_start_d = 1'b1;
        state_d     = C12;
`ifdef PALSEQ_SKIP_SEL_EN
        shadow_wr     = 1'b1;
        shadow_wr_pal = pal_q;
`endif
      end
      C12: if (!cmd_hold) begin
        cmd_out_d   = c12_word(colors_q);
        cmd_start_d = 1'b1;
        state_d     = C34;
      end
      C34: if (!cmd_hold) begin
        cmd_out_d   = c34_word(colors_q);
        cmd_start_d = 1'b1;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      ONE: if (!cmd_hold) begin
        cmd_out_d   = one_word(kind_q, delta_q);
        cmd_start_d = 1'b1;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_out_q   <= 24'h0;
      cmd_start_q <= 1'b0;
      done_q      <= 1'b0;
      kind_q      <= 2'd0;
      pal_q       <= 3'd0;
      colors_q    <= 20'd0;
      delta_q     <= 7'd0;
    end else begin
      state_q     <= state_d;
      cmd_out_q   <= cmd_out_d;
      cmd_start_q <= cmd_start_d;
      done_q      <= done_d;
      kind_q      <= kind_d;
      pal_q       <= pal_d;
      colors_q    <= colors_d;
      delta_q     <= delta_d;
    end
  end

  assign cmd_out   = cmd_out_q;
  assign cmd_start = cmd_start_q;
  assign done      = done_q;

endmodule

// File: tb/tb_palette_cmd_sequencer.sv
// Scoreboard bench for palette_cmd_sequencer; expected command words are queued at request time.
module tb_palette_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_kind = 2'd0;
  logic [2:0]  req_pal = 3'd0;
  logic [19:0] req_colors = 20'd0;
  logic [6:0]  req_delta = 7'd0;
  logic        cmd_hold = 1'b0;
  logic [23:0] cmd_out;
  logic        cmd_start;
  logic        done;

  palette_cmd_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_pal(req_pal), .req_colors(req_colors), .req_delta(req_delta),
    .cmd_hold(cmd_hold), .cmd_out(cmd_out), .cmd_start(cmd_start), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [24:0] sb[$];
  logic rand_hold = 1'b0;
`ifdef PALSEQ_SKIP_SEL_EN
  logic       m_vld = 1'b0;
  logic [2:0] m_pal = 3'd0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: expected {done, cmd_word} entries for one request.
  task automatic push_expected(input logic [1:0] k, input logic [2:0] p,
                               input logic [19:0] c, input logic [6:0] d);
    logic skip;
    skip = 1'b0;
    if (k == 2'd0) begin
`ifdef PALSEQ_SKIP_SEL_EN
      skip = m_vld && (m_pal == p);
      m_vld = 1'b1;
      m_pal = p;
`endif
      if (!skip) sb.push_back({1'b0, 8'h03, 13'h0, p});
      sb.push_back({1'b0, 8'h04, 6'h0, c[9:5], c[4:0]});
      sb.push_back({1'b1, 8'h05, 6'h0, c[19:15], c[14:10]});
    end else if (k == 2'd1) begin
      sb.push_back({1'b1, 8'h01, 9'h0, d});
    end else if (k == 2'd2) begin
      sb.push_back({1'b1, 8'h02, 11'h0, d[4:0]});
    end else begin
      sb.push_back({1'b1, 8'h24, 16'h0000});
    end
  endtask

  // Monitor: pops and compares on every strobe, checks hold/ready/stability rules.
  logic        hold_at_edge = 1'b0;
  logic [23:0] prev_out = 24'h0;
  logic        prev_rst = 1'b1;
  logic        done_seen = 1'b0;

  always @(posedge clk) hold_at_edge <= cmd_hold;

  always @(negedge clk) begin
    logic [24:0] e;
    if (!rst && !prev_rst) begin
      if (done_seen) check("ready_after_done", {31'd0, req_ready}, 32'd1);
      if (hold_at_edge) check("hold_no_strobe", {31'd0, cmd_start}, 32'd0);
      if (cmd_start) begin
        if (sb.size() == 0) begin
          check("unexpected_cmd", {8'd0, cmd_out}, 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          check("cmd_out", {8'd0, cmd_out}, {8'd0, e[23:0]});
          check("done", {31'd0, done}, {31'd0, e[24]});
          if (!done) check("ready_busy", {31'd0, req_ready}, 32'd0);
          else       check("ready_in_done", {31'd0, req_ready}, 32'd0);
        end
      end else begin
        check("cmd_out_hold", {8'd0, cmd_out}, {8'd0, prev_out});
        if (done) check("done_no_strobe", {31'd0, done}, 32'd0);
      end
    end
    done_seen <= done && cmd_start && !rst;
    prev_out  <= cmd_out;
    prev_rst  <= rst;
  end

  task automatic send(input logic [1:0] k, input logic [2:0] p,
                      input logic [19:0] c, input logic [6:0] d);
    logic h;
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    check("ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_kind   = k;
    req_pal    = p;
    req_colors = c;
    req_delta  = d;
    push_expected(k, p, c, d);
    @(posedge clk);
    h = cmd_hold;
    #1;
    req_valid  = 1'b0;
    req_kind   = 2'($urandom);
    req_pal    = 3'($urandom);
    req_colors = 20'($urandom);
    req_delta  = 7'($urandom);
    @(negedge clk);
    if (!h) check("latency1", {31'd0, cmd_start}, 32'd1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rand_hold) cmd_hold = ($urandom_range(0, 2) == 0);
      else           cmd_hold = 1'b0;
      if (sb.size() == 0 && req_ready && !cmd_hold) break;
    end
    cmd_hold = 1'b0;
    check("drain", sb.size(), 32'd0);
  endtask

  localparam logic [19:0] COLS_1234 = {5'd4, 5'd3, 5'd2, 5'd1};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cmd_out", {8'd0, cmd_out}, 32'd0);
    check("rst_cmd_start", {31'd0, cmd_start}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Basic palette load and the three single-command kinds.
    send(2'd0, 3'd2, COLS_1234, 7'd0);
    wait_idle();
    send(2'd2, 3'd0, 20'd0, 7'h3F);
    send(2'd1, 3'd0, 20'd0, 7'h55);
    send(2'd3, 3'd0, 20'd0, 7'h00);
    wait_idle();

    // Downstream stall in the middle of a palette load.
    send(2'd0, 3'd1, 20'hABCDE, 7'd0);
    cmd_hold = 1'b1;
    repeat (3) @(negedge clk);
    cmd_hold = 1'b0;
    wait_idle();

    // Accept while stalled.
    cmd_hold = 1'b1;
    send(2'd1, 3'd0, 20'd0, 7'h2A);
    @(negedge clk);
    cmd_hold = 1'b0;
    wait_idle();

    // Reset between C12 and C34 aborts the request.
    send(2'd0, 3'd3, COLS_1234, 7'd0);
    for (int i = 0; i < 50; i++) begin
      if (cmd_start && cmd_out[23:16] == 8'h04) break;
      @(negedge clk);
    end
    rst = 1'b1;
    sb.delete();
`ifdef PALSEQ_SKIP_SEL_EN
    m_vld = 1'b0;
`endif
    #1;
    check("abort_cmd_out", {8'd0, cmd_out}, 32'd0);
    check("abort_cmd_start", {31'd0, cmd_start}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    send(2'd0, 3'd3, COLS_1234, 7'd0);
    wait_idle();

    // Repeated palette numbers exercise the select-skip path when it is built in.
    send(2'd0, 3'd5, 20'h12345, 7'd0);
    send(2'd0, 3'd5, 20'h54321, 7'd0);
    send(2'd0, 3'd6, 20'h0F0F0, 7'd0);
    send(2'd1, 3'd0, 20'd0, 7'h11);
    send(2'd0, 3'd6, 20'hF0F0F, 7'd0);
    send(2'd0, 3'd5, 20'h33333, 7'd0);
    wait_idle();

    // Random requests with random stalls.
    rand_hold = 1'b1;
    for (int n = 0; n < 16; n++) begin
      send(2'($urandom), 3'($urandom_range(5, 6)), 20'($urandom), 7'($urandom));
      wait_idle();
    end
    rand_hold = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/palette_cmd_sequencer.md
PALETTE_CMD_SEQUENCER -- requirements
Module: palette_cmd_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 req_valid  input  1  request present.
REQ-004 req_ready  output  1  high only in IDLE; request accepted on the cycle where req_valid && req_ready.
REQ-005 req_kind  input  2  0=palette load, 1=set delta X, 2=set delta Y, 3=raise display IRQ.
REQ-006 req_pal  input  3  target palette number 0..7 (kind 0 only).
REQ-007 req_colors  input  20  {col4,col3,col2,col1}, 5 bits each, col1 in [4:0] (kind 0 only).
REQ-008 req_delta  input  7  delta value (kinds 1, 2).
REQ-009 cmd_hold  input  1  downstream stall; no command is issued while high.
REQ-010 cmd_out  output  24  command word: [23:16] opcode, [15:0] payload.
REQ-011 cmd_start  output  1  one-cycle strobe; cmd_out valid when high.
REQ-012 done  output  1  one-cycle pulse coincident with cmd_start of the last command of a request.

Function
REQ-013 States: IDLE, SEL, C12, C34, ONE; the FSM SHALL be the only source of cmd_start.
REQ-014 On accept: req fields SHALL be captured into internal registers; kind 0 -> SEL, kinds 1-3 -> ONE.
REQ-015 cmd_out, cmd_start, done SHALL be registered; first cmd_start SHALL occur the cycle after accept when cmd_hold is low (latency 1).
REQ-016 SEL: issue opcode 8'd3, payload {13'b0, 0, pal}; -> C12.
REQ-017 C12: issue opcode 8'd4, payload {6'b0, col2, col1}; -> C34.
REQ-018 C34: issue opcode 8'd5, payload {6'b0, col4, col3}, assert done; -> IDLE.
REQ-019 ONE: kind 1 -> opcode 8'd1, payload {9'b0, delta[6:0]}; kind 2 -> opcode 8'd2, payload {11'b0, delta[4:0]} (bits [6:5] discarded); kind 3 -> opcode 8'd36, payload 16'h0000; assert done; -> IDLE.
REQ-020 Unused payload bits SHALL be zero; cmd_out SHALL hold its last value when cmd_start is low.
REQ-021 While cmd_hold is high in SEL/C12/C34/ONE: state, cmd_out hold, cmd_start=0, done=0; issue resumes the cycle after cmd_hold falls.
REQ-022 Consecutive commands of one request SHALL be issued on consecutive cycles absent cmd_hold (palette load = 3 cycles).
REQ-023 req_ready SHALL be 0 from the accept cycle's next edge until the cycle after done; back-to-back requests SHALL therefore have at least one idle cycle between done and the next first cmd_start.
REQ-024 Changes on req_* after accept SHALL not affect the in-flight request.
REQ-025 cmd_hold SHALL not gate acceptance; a request may be accepted while cmd_hold is high.

Reset
REQ-026 On rst: state=IDLE, cmd_out=24'h0, cmd_start=0, done=0, captured fields=0, shadow palette invalid.
REQ-027 Reset mid-request SHALL abort it with no further cmd_start; req_ready=1 the first cycle after rst falls.

Configuration
REQ-028 Macro PALSEQ_SKIP_SEL_EN: when defined, a 3-bit shadow of the last issued opcode-3 palette number plus valid bit SHALL be kept; a palette load whose req_pal equals the valid shadow SHALL go directly to C12 (2 commands, first cmd_start at latency 1).
REQ-029 Shadow SHALL be updated on every issued opcode 3 and invalidated on reset only; kinds 1-3 SHALL not affect it.
REQ-030 Without PALSEQ_SKIP_SEL_EN: every palette load SHALL issue SEL, C12, C34; no shadow logic present.

Verification
REQ-031 Palette load pal=2, colors={4'd..: col1=1,col2=2,col3=3,col4=4} -> cmd_out 0x030002, 0x030000+... i.e. 0x030002, 0x040041, 0x050083 on cycles 1,2,3; done with 0x050083.
REQ-032 kind 2, delta=7'h3F -> single cmd 0x02001F, done same cycle; kind 1, delta=7'h55 -> 0x010055; kind 3 -> 0x240000.
REQ-033 Palette load with cmd_hold high cycles 2-4 -> 0x040041 issued cycle 5 after release, no strobe during hold, cmd_out stable.
REQ-034 rst asserted between C12 and C34 -> no 0x05xxxx issued, req_ready=1 after release, next request runs full sequence.
REQ-035 PALSEQ_SKIP_SEL_EN defined: two loads pal=5 back-to-back -> second emits only opcodes 4,5; with a pal=6 load between -> opcode 3 reissued; macro undefined -> opcode 3 always issued.
